// File: rtl/sys_defs.sv
// Shared types and defaults for the unified-memory port arbiter.
package sys_defs;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'b00,
        CMD_LOAD  = 2'b01,
        CMD_STORE = 2'b10
    } mem_cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10
    } arb_state_t;

    localparam int unsigned DEF_MEM_LATENCY  = 2;
    localparam int unsigned DEF_STARVE_LIMIT = 4;
    localparam int unsigned CNT_W            = 4;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/arb_latency_counter.sv
// Load/increment/compare counter: i_load starts it at 1, o_done marks count==LATENCY.
// The count returns to 0 after the done cycle unless reloaded; no backpressure.
module arb_latency_counter
    import sys_defs::*;
#(
    parameter int unsigned LATENCY = DEF_MEM_LATENCY
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    output logic o_done
);

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(1);
        end else if (r_cnt == LAT_C) begin
            r_cnt <= '0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_done = (r_cnt == LAT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM requesters onto one fixed-latency memory; one transaction in flight,
// grant-to-rvalid latency MEM_LATENCY; requesters are held off with level stalls.
module mem_port_arbiter
    import sys_defs::*;
#(
    parameter int unsigned MEM_LATENCY  = DEF_MEM_LATENCY,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    output logic        if_rvalid,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_rvalid,
    output logic        d_stall,
    output logic [1:0]  mem_cmd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] STARVE_C = CNT_W'(STARVE_LIMIT);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_flushed;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    mem_cmd_t         w_cmd;
    logic             w_grant_d;
    logic             w_grant_i;
    logic             w_done;

    arb_latency_counter #(
        .LATENCY (MEM_LATENCY)
    ) u_lat_cnt (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_load  (w_grant_d | w_grant_i),
        .o_done  (w_done)
    );

    // Grants are gated by rst so a request held during reset never issues a command.
    always_comb begin
        w_grant_d = 1'b0;
        w_grant_i = 1'b0;
        if (rst && (r_state == IDLE)) begin
            w_grant_d = d_req && (!if_req || (r_starve_cnt < STARVE_C));
            w_grant_i = if_req && (!d_req || (r_starve_cnt >= STARVE_C));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd       = CMD_NONE;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt = BUSY_D;
                    w_cmd       = d_we ? CMD_STORE : CMD_LOAD;
                    mem_addr    = word_align(d_addr);
                    mem_wdata   = d_wdata;
                end else if (w_grant_i) begin
                    w_state_nxt = BUSY_I;
                    w_cmd       = CMD_LOAD;
                    mem_addr    = word_align(if_addr);
                end
            end
            BUSY_I, BUSY_D: begin
                mem_addr  = r_addr;
                mem_wdata = r_wdata;
                if (w_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign mem_cmd = w_cmd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant_d) begin
            r_addr  <= word_align(d_addr);
            r_wdata <= d_wdata;
        end else if (w_grant_i) begin
            r_addr  <= word_align(if_addr);
            r_wdata <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (w_grant_i || !if_req) begin
                r_starve_cnt <= '0;
            end else if (w_grant_d && (r_starve_cnt < STARVE_C)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end
    end

    // A flushed fetch still occupies the memory for its full latency; only the return is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flushed <= 1'b0;
        end else if (w_done) begin
            r_flushed <= 1'b0;
        end else if ((r_state == BUSY_I) && if_flush) begin
            r_flushed <= 1'b1;
        end
    end

    assign if_rvalid = (r_state == BUSY_I) && w_done && !r_flushed && !if_flush;
    assign d_rvalid  = (r_state == BUSY_D) && w_done;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;
    assign if_stall  = if_req && !if_rvalid;
    assign d_stall   = d_req && !d_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LATENCY=2, STARVE_LIMIT=4).
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        if_rvalid;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_rvalid;
    logic        d_stall;
    logic [1:0]  mem_cmd;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(
        .MEM_LATENCY  (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_rdata  (if_rdata),
        .if_rvalid (if_rvalid),
        .if_stall  (if_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_rvalid  (d_rvalid),
        .d_stall   (d_stall),
        .mem_cmd   (mem_cmd),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs are driven 2 time units after the rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        #3;
        chk("rst_cmd", 32'(mem_cmd), 32'd0);
        chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        cyc(); rst = 1'b1;

        // Single fetch, unaligned address
        cyc(); if_req = 1'b1; if_addr = 32'h0000_0006; #1;
        chk("f1_cmd_T", 32'(mem_cmd), 32'd1);
        chk("f1_addr_T", mem_addr, 32'h0000_0004);
        chk("f1_stall_T", 32'(if_stall), 32'd1);
        cyc(); #1;
        chk("f1_cmd_T1", 32'(mem_cmd), 32'd0);
        chk("f1_stall_T1", 32'(if_stall), 32'd1);
        chk("f1_rvalid_T1", 32'(if_rvalid), 32'd0);
        cyc(); mem_rdata = 32'hCAFE_0001; #1;
        chk("f1_rvalid_T2", 32'(if_rvalid), 32'd1);
        chk("f1_rdata_T2", if_rdata, 32'hCAFE_0001);
        chk("f1_stall_T2", 32'(if_stall), 32'd0);
        cyc(); if_req = 1'b0; mem_rdata = '0; #1;
        chk("f1_idle_cmd", 32'(mem_cmd), 32'd0);

        // Simultaneous requests: data first, IF after
        cyc(); if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; #1;
        chk("sim_cmd_T", 32'(mem_cmd), 32'd1);
        chk("sim_addr_T", mem_addr, 32'h100);
        chk("sim_if_stall_T", 32'(if_stall), 32'd1);
        chk("sim_d_stall_T", 32'(d_stall), 32'd1);
        cyc();
        cyc(); mem_rdata = 32'hD0D0_0100; #1;
        chk("sim_d_rvalid_T2", 32'(d_rvalid), 32'd1);
        chk("sim_d_rdata_T2", d_rdata, 32'hD0D0_0100);
        chk("sim_d_stall_T2", 32'(d_stall), 32'd0);
        chk("sim_if_rvalid_T2", 32'(if_rvalid), 32'd0);
        cyc(); d_req = 1'b0; mem_rdata = '0; #1;
        chk("sim_if_cmd_T3", 32'(mem_cmd), 32'd1);
        chk("sim_if_addr_T3", mem_addr, 32'h200);
        cyc();
        cyc(); mem_rdata = 32'h1111_0200; #1;
        chk("sim_if_rvalid_T5", 32'(if_rvalid), 32'd1);
        chk("sim_if_rdata_T5", if_rdata, 32'h1111_0200);
        cyc(); if_req = 1'b0; mem_rdata = '0;

        // Back-to-back stores vs. continuous fetch: grant 4 and 9 go to IF
        for (int g = 0; g < 10; g++) begin
            logic is_if;
            is_if = (g == 4) || (g == 9);
            cyc();
            if_req = 1'b1; if_addr = 32'h300;
            d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40 + 32'(g * 4); d_wdata = 32'hA000_0000 + 32'(g);
            #1;
            chk($sformatf("stv_cmd_g%0d", g), 32'(mem_cmd), is_if ? 32'd1 : 32'd2);
            chk($sformatf("stv_addr_g%0d", g), mem_addr, is_if ? 32'h300 : 32'h40 + 32'(g * 4));
            cyc();
            cyc(); #1;
            chk($sformatf("stv_d_rvalid_g%0d", g), 32'(d_rvalid), is_if ? 32'd0 : 32'd1);
            chk($sformatf("stv_if_rvalid_g%0d", g), 32'(if_rvalid), is_if ? 32'd1 : 32'd0);
        end
        cyc(); if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; #1;
        chk("stv_idle_cmd", 32'(mem_cmd), 32'd0);

        // Flush during a fetch
        cyc(); if_req = 1'b1; if_addr = 32'h500; #1;
        chk("fl_cmd_T", 32'(mem_cmd), 32'd1);
        cyc(); if_flush = 1'b1; #1;
        chk("fl_stall_T1", 32'(if_stall), 32'd1);
        chk("fl_cmd_T1", 32'(mem_cmd), 32'd0);
        cyc(); if_flush = 1'b0; if_addr = 32'h600; mem_rdata = 32'hBAD0_0500; #1;
        chk("fl_rvalid_T2", 32'(if_rvalid), 32'd0);
        chk("fl_rdata_T2", if_rdata, 32'h0);
        chk("fl_stall_T2", 32'(if_stall), 32'd1);
        chk("fl_cmd_T2", 32'(mem_cmd), 32'd0);
        cyc(); mem_rdata = '0; #1;
        chk("fl_cmd_T3", 32'(mem_cmd), 32'd1);
        chk("fl_addr_T3", mem_addr, 32'h600);
        cyc(); #1;
        chk("fl_stall_T4", 32'(if_stall), 32'd1);
        cyc(); mem_rdata = 32'h600D_0600; #1;
        chk("fl_rvalid_T5", 32'(if_rvalid), 32'd1);
        chk("fl_rdata_T5", if_rdata, 32'h600D_0600);
        chk("fl_stall_T5", 32'(if_stall), 32'd0);
        cyc(); if_req = 1'b0; mem_rdata = '0;

        // Reset during a data load
        cyc(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; #1;
        chk("rs_cmd_T", 32'(mem_cmd), 32'd1);
        cyc(); rst = 1'b0; #1;
        chk("rs_cmd_T1", 32'(mem_cmd), 32'd0);
        chk("rs_addr_T1", mem_addr, 32'h0);
        chk("rs_d_rvalid_T1", 32'(d_rvalid), 32'd0);
        cyc(); mem_rdata = 32'hDEAD_0080; #1;
        chk("rs_d_rvalid_T2", 32'(d_rvalid), 32'd0);
        chk("rs_d_rdata_T2", d_rdata, 32'h0);
        d_req = 1'b0; rst = 1'b1;
        cyc(); #1;
        chk("rs_d_rvalid_T3", 32'(d_rvalid), 32'd0);
        chk("rs_cmd_T3", 32'(mem_cmd), 32'd0);
        cyc(); mem_rdata = '0; #1;
        chk("rs_d_rvalid_T4", 32'(d_rvalid), 32'd0);
        chk("rs_cmd_T4", 32'(mem_cmd), 32'd0);

        // Store with wdata
        cyc(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h123; d_wdata = 32'hDEAD_BEEF; #1;
        chk("st_cmd_T", 32'(mem_cmd), 32'd2);
        chk("st_wdata_T", mem_wdata, 32'hDEAD_BEEF);
        chk("st_addr_T", mem_addr, 32'h120);
        chk("st_stall_T", 32'(d_stall), 32'd1);
        cyc(); d_wdata = 32'h0BAD_0BAD; #1;
        chk("st_cmd_T1", 32'(mem_cmd), 32'd0);
        chk("st_stall_T1", 32'(d_stall), 32'd1);
        cyc(); #1;
        chk("st_rvalid_T2", 32'(d_rvalid), 32'd1);
        chk("st_stall_T2", 32'(d_stall), 32'd0);
        cyc(); d_req = 1'b0; d_we = 1'b0; #1;
        chk("st_idle_cmd", 32'(mem_cmd), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage).
- Grants one transaction at a time and drives the memory command.
- Returns read data to the owning requester and generates per-requester stall signals for the pipeline.
- Data requests win by default; an anti-starvation counter guarantees fetch progress.

Parameters:
- MEM_LATENCY, 2, cycles from command issue to mem_rdata valid; legal range 1..15.
- STARVE_LIMIT, 4, consecutive data grants made while if_req is pending, after which IF gets priority once; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  IF requests an instruction read.
- if_addr  in  32  fetch address.
- if_flush  in  1  branch taken; cancels the outstanding fetch.
- if_rdata  out  32  fetched instruction.
- if_rvalid  out  1  if_rdata valid, one-cycle pulse.
- if_stall  out  1  IF must hold PC.
- d_req  in  1  MEM stage requests an access.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data.
- d_rvalid  out  1  access complete (load data valid, or store done), one-cycle pulse.
- d_stall  out  1  MEM stage must hold.
- mem_cmd  out  2  00 NONE, 01 LOAD, 10 STORE; 11 is never driven.
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  memory read data, valid MEM_LATENCY cycles after the command.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, latency counter 0, starvation counter 0, flushed flag 0, owner none.
- Reset drives: mem_cmd=NONE, if_rvalid=0, d_rvalid=0. All data outputs and mem_addr/mem_wdata are 0.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE, grant decision (combinational, same cycle T):
  - d_req and (not if_req or starve_cnt<STARVE_LIMIT): grant data. mem_cmd=STORE if d_we else LOAD; mem_addr/mem_wdata from d_*; next state BUSY_D.
  - if_req and (not d_req or starve_cnt>=STARVE_LIMIT): grant IF. mem_cmd=LOAD; next state BUSY_I.
  - Neither request: mem_cmd=NONE; stay IDLE.
- mem_cmd is non-NONE only in IDLE grant cycles, for exactly one cycle.
- Starvation counter:
  - Increments on each data grant made while if_req=1, saturating at STARVE_LIMIT.
  - Clears on any IF grant.
  - Clears when if_req=0 in IDLE.
- BUSY_x: latency counter starts at 1 after the grant and increments each cycle. In cycle T+MEM_LATENCY (counter==MEM_LATENCY):
  - The owner's rvalid=1 and rdata=mem_rdata, passed through combinationally.
  - Next state IDLE.
- Minimum spacing between grants: MEM_LATENCY+1 cycles.
- Stalls:
  - if_stall = if_req and not if_rvalid.
  - d_stall = d_req and not d_rvalid.
- if_flush:
  - In BUSY_I before or at the completion cycle: set the flushed flag. At completion if_rvalid=0, and the FSM still waits out the full latency.
  - Flag clears on return to IDLE.
  - In IDLE or BUSY_D: no effect.
- Requesters hold req/addr/data stable until their rvalid. Changes while granted are ignored; captured values are used. The arbiter registers addr/wdata at grant.
- Reset asserted mid-transaction: the transaction is abandoned and any later mem_rdata is ignored. There is no rvalid after reset release.
- Simultaneous if_req and d_req in IDLE with starve_cnt==STARVE_LIMIT: IF wins.

Decomposition:
- Shared package (sys_defs): mem_cmd_t enum (NONE/LOAD/STORE) and arb_state_t enum (IDLE/BUSY_I/BUSY_D).
- MEM_LATENCY and STARVE_LIMIT defaults live in the package as constants.
- One natural sub-module: arb_latency_counter, a load/increment/compare counter with a done flag, reusable for other fixed-latency resources.
- Everything else stays in one module.

Test Plan:
- Reset, then if_req=1, if_addr=0x0000_0006 only:
  - mem_cmd=LOAD, mem_addr=0x0000_0004 in cycle T.
  - if_rvalid=1 with if_rdata=mem_rdata in T+2.
  - if_stall=1 in T..T+1.
- if_req and d_req (load, d_addr=0x100) together in IDLE: data granted first with d_rvalid at T+2; IF granted at T+3 with if_rvalid at T+5.
- d_req held continuously (back-to-back stores) plus if_req: after 4 data grants, the 5th grant is IF; the starvation counter is 0 afterwards.
- IF grant at T, if_flush pulsed at T+1: no if_rvalid at T+2, no new grant before T+3, if_stall stays 1 until the re-fetch completes.
- rst low at T+1 during BUSY_D: outputs go to reset values immediately; after release there is no d_rvalid and mem_cmd=NONE until a new request.
- Store with d_we=1, d_wdata=0xDEADBEEF: mem_cmd=STORE, mem_wdata=0xDEADBEEF for one cycle, d_rvalid at T+2, d_stall deasserted in T+2.
